// File: rtl/param_priority_encoder.sv
// -----------------------------------------------------------------------------
// param_priority_encoder
//
// Accepts a request vector and then emits the index of every set bit, one
// index per handshake, in the priority order chosen by the mode latched with
// the vector. There are three orderings: low-priority (bit 0 first),
// high-priority (MSB first) and round-robin. Round-robin starts its search at a
// pointer that persists across vectors and advances past each granted index.
// Every output comes straight from a flop.
//
// Parameters
//   DATA_WIDTH        request vector width (>= 2)
//   ENC_WIDTH         index width, defaults to $clog2(DATA_WIDTH)
//
// Ports
//   Clock_In            in   rising-edge clock
//   Reset_n_In          in   asynchronous active-low reset
//   Enable_In           in   block enable; low freezes all state
//   Flush_In            in   synchronous abort of the vector in progress
//   Mode_In[1:0]        in   00 low-prio, 01 high-prio, 10 round-robin, 11 = 00
//   Data_In             in   request vector
//   Data_Valid_In       in   Data_In valid
//   Data_Ready_Out      out  block accepts a vector (IDLE and enabled)
//   Encoded_Value_Out   out  granted index
//   Encoded_Valid_Out   out  Encoded_Value_Out valid
//   Encoded_Ready_In    in   downstream accepts the index
//   Last_Out            out  presented index is the final set bit
//   Remaining_Out       out  set bits still pending, including the presented one
//   No_Match_Out        out  one-cycle pulse when an all-zero vector is accepted
//   Fsm_State_Out       out  current FSM state (0 = IDLE, 1 = DRAIN)
//
// Handshake rules (both sides): a transfer happens at a rising edge where valid
// and ready are both high and Enable_In is high. A valid side keeps its payload
// stable until the transfer. Valid never waits for ready. On the input side the
// transfer is "accept" (Data_Valid_In & Data_Ready_Out). On the output side it
// is "handshake" (Encoded_Valid_Out & Encoded_Ready_In).
// -----------------------------------------------------------------------------
module param_priority_encoder #(
   parameter int DATA_WIDTH = 32,
   parameter int ENC_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  Clock_In,
   input  logic                  Reset_n_In,
   input  logic                  Enable_In,
   input  logic                  Flush_In,
   input  logic [1:0]            Mode_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   input  logic                  Data_Valid_In,
   output logic                  Data_Ready_Out,
   output logic [ENC_WIDTH-1:0]  Encoded_Value_Out,
   output logic                  Encoded_Valid_Out,
   input  logic                  Encoded_Ready_In,
   output logic                  Last_Out,
   output logic [ENC_WIDTH:0]    Remaining_Out,
   output logic                  No_Match_Out,
   output logic                  Fsm_State_Out
);

   localparam logic [1:0] MODE_LOW  = 2'b00;
   localparam logic [1:0] MODE_HIGH = 2'b01;
   localparam logic [1:0] MODE_RR   = 2'b10;

   localparam logic [ENC_WIDTH:0]   REM_ONE  = {{ENC_WIDTH{1'b0}}, 1'b1};
   localparam logic [ENC_WIDTH-1:0] ENC_ONE  = {{(ENC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ENC_WIDTH-1:0] ENC_LAST = ENC_WIDTH'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] BIT0    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // --------------------------------------------------------------------------
   // Registered state and outputs
   // --------------------------------------------------------------------------
   state_t                state_q,    state_d;
   logic [DATA_WIDTH-1:0] mask_q,     mask_d;
   logic [1:0]            mode_q,     mode_d;
   logic [ENC_WIDTH-1:0]  rr_ptr_q,   rr_ptr_d;
   logic [ENC_WIDTH-1:0]  value_q,    value_d;
   logic                  valid_q,    valid_d;
   logic                  last_q,     last_d;
   logic [ENC_WIDTH:0]    rem_q,      rem_d;
   logic                  no_match_q, no_match_d;
   logic                  ready_q,    ready_d;

   // --------------------------------------------------------------------------
   // Helper functions
   // --------------------------------------------------------------------------

   // Highest-priority set bit of m under mode md. Round-robin scans upward
   // from ptr and wraps at DATA_WIDTH-1. An empty mask returns 0. Callers only
   // use the result for nonzero masks.
   function automatic logic [ENC_WIDTH-1:0] pick_index(
      input logic [DATA_WIDTH-1:0] m,
      input logic [1:0]            md,
      input logic [ENC_WIDTH-1:0]  ptr
   );
      logic [ENC_WIDTH-1:0]  idx;
      logic [DATA_WIDTH-1:0] sh;
      logic                  found;
      int                    pos;
      idx   = '0;
      found = 1'b0;
      case (md)
         MODE_HIGH: begin
            for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
               sh = m >> i;
               if (!found && sh[0]) begin
                  idx   = ENC_WIDTH'(i);
                  found = 1'b1;
               end
            end
         end
         MODE_RR: begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
               pos = int'(ptr) + i;
               if (pos >= DATA_WIDTH) pos = pos - DATA_WIDTH;
               sh = m >> pos;
               if (!found && sh[0]) begin
                  idx   = ENC_WIDTH'(pos);
                  found = 1'b1;
               end
            end
         end
         default: begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
               sh = m >> i;
               if (!found && sh[0]) begin
                  idx   = ENC_WIDTH'(i);
                  found = 1'b1;
               end
            end
         end
      endcase
      return idx;
   endfunction

   function automatic logic [ENC_WIDTH:0] popcount(input logic [DATA_WIDTH-1:0] m);
      logic [ENC_WIDTH:0]    cnt;
      logic [DATA_WIDTH-1:0] sh;
      cnt = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         sh  = m >> i;
         cnt = cnt + {{ENC_WIDTH{1'b0}}, sh[0]};
      end
      return cnt;
   endfunction

   // --------------------------------------------------------------------------
   // Transfer strobes and derived values
   // --------------------------------------------------------------------------
   logic                  accept;
   logic                  handshake;
   logic [1:0]            acc_mode;
   logic [DATA_WIDTH-1:0] cleared_mask;
   logic [ENC_WIDTH-1:0]  ptr_after_grant;

   assign accept    = Data_Valid_In & ready_q & Enable_In;
   assign handshake = valid_q & Encoded_Ready_In & Enable_In;

   // Mode 11 is an alias of low-priority. It is folded here so the latched
   // mode only ever holds the three real orderings.
   assign acc_mode = (Mode_In == 2'b11) ? MODE_LOW : Mode_In;

   assign cleared_mask    = mask_q & ~(BIT0 << value_q);
   assign ptr_after_grant = (value_q == ENC_LAST) ? '0 : value_q + ENC_ONE;

   // --------------------------------------------------------------------------
   // Next-state / next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      mode_d     = mode_q;
      rr_ptr_d   = rr_ptr_q;
      value_d    = value_q;
      valid_d    = 1'b0;
      rem_d      = rem_q;
      no_match_d = 1'b0;
      ready_d    = 1'b0;
      last_d     = 1'b0;

      if (Flush_In) begin
         // Flush wins over accept, handshake and the enable. The round-robin
         // pointer is deliberately kept.
         state_d = ST_IDLE;
         mask_d  = '0;
         rem_d   = '0;
         ready_d = Enable_In;
      end else if (!Enable_In) begin
         // Hold everything. Valid, ready and no-match drop so that no transfer
         // can be seen while disabled. Valid comes back one cycle after
         // re-enable because it is rebuilt from the DRAIN state below.
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               ready_d = 1'b1;
               if (accept) begin
                  mode_d = acc_mode;
                  mask_d = Data_In;
                  if (Data_In != '0) begin
                     state_d = ST_DRAIN;
                     value_d = pick_index(Data_In, acc_mode, rr_ptr_q);
                     rem_d   = popcount(Data_In);
                     valid_d = 1'b1;
                     ready_d = 1'b0;
                  end else begin
                     no_match_d = 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               valid_d = 1'b1;
               if (handshake) begin
                  mask_d = cleared_mask;
                  rem_d  = rem_q - REM_ONE;
                  if (mode_q == MODE_RR) rr_ptr_d = ptr_after_grant;
                  if (cleared_mask == '0) begin
                     state_d = ST_IDLE;
                     valid_d = 1'b0;
                     ready_d = 1'b1;
                     rem_d   = '0;
                  end else begin
                     // Search from the updated pointer so that back-to-back
                     // round-robin grants follow one another.
                     value_d = pick_index(cleared_mask, mode_q, rr_ptr_d);
                  end
               end
            end
         endcase
      end

      last_d = valid_d && (rem_d == REM_ONE);
   end

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         state_q    <= ST_IDLE;
         mask_q     <= '0;
         mode_q     <= MODE_LOW;
         rr_ptr_q   <= '0;
         value_q    <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         rem_q      <= '0;
         no_match_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         mode_q     <= mode_d;
         rr_ptr_q   <= rr_ptr_d;
         value_q    <= value_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         rem_q      <= rem_d;
         no_match_q <= no_match_d;
         ready_q    <= ready_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign Data_Ready_Out    = ready_q;
   assign Encoded_Value_Out = value_q;
   assign Encoded_Valid_Out = valid_q;
   assign Last_Out          = last_q;
   assign Remaining_Out     = rem_q;
   assign No_Match_Out      = no_match_q;
   assign Fsm_State_Out     = state_q;

endmodule

// File: tb/tb_param_priority_encoder.sv
// -----------------------------------------------------------------------------
// tb_param_priority_encoder
//
// Directed bench for param_priority_encoder at DATA_WIDTH = 8. A table of
// {mode, vector, expected index order} records is drained under continuous
// downstream ready. Hand-written sequences then cover back-pressure, the
// all-zero vector, enable low, flush and reset mid-drain.
// Inputs are driven, and outputs are sampled, 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_param_priority_encoder;

   localparam int DW = 8;
   localparam int EW = 3;

   // ---------------------------------------------------------------- clock/reset
   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic enable     = 1'b1;
   logic flush      = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [DW-1:0] data = '0;
   logic data_valid = 1'b0;
   logic enc_ready  = 1'b1;

   logic          data_ready;
   logic [EW-1:0] enc_value;
   logic          enc_valid;
   logic          last;
   logic [EW:0]   remaining;
   logic          no_match;
   logic          fsm_state;

   always #5 clk = ~clk;

   param_priority_encoder #(.DATA_WIDTH(DW), .ENC_WIDTH(EW)) dut (
      .Clock_In          (clk),
      .Reset_n_In        (rst_n),
      .Enable_In         (enable),
      .Flush_In          (flush),
      .Mode_In           (mode),
      .Data_In           (data),
      .Data_Valid_In     (data_valid),
      .Data_Ready_Out    (data_ready),
      .Encoded_Value_Out (enc_value),
      .Encoded_Valid_Out (enc_valid),
      .Encoded_Ready_In  (enc_ready),
      .Last_Out          (last),
      .Remaining_Out     (remaining),
      .No_Match_Out      (no_match),
      .Fsm_State_Out     (fsm_state)
   );

   // ---------------------------------------------------------------- scoreboard
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (!data_ready && k < 20) begin
         step();
         k++;
      end
      chk({tag, " ready before send"}, int'(data_ready), 1);
   endtask

   task automatic send(input logic [1:0] m, input logic [DW-1:0] d);
      mode       = m;
      data       = d;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      // Scramble the mode and data so that any use of the live inputs during
      // the drain shows up as a wrong index.
      mode       = ~m;
      data       = DW'($urandom_range(0, 255));
   endtask

   task automatic chk_idx(input string tag, input int value, input int rem, input int is_last);
      chk({tag, " valid"},     int'(enc_valid), 1);
      chk({tag, " value"},     int'(enc_value), value);
      chk({tag, " remaining"}, int'(remaining), rem);
      chk({tag, " last"},      int'(last),      is_last);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " idle valid"},     int'(enc_valid), 0);
      chk({tag, " idle remaining"}, int'(remaining), 0);
      chk({tag, " idle last"},      int'(last),      0);
      chk({tag, " idle ready"},     int'(data_ready), 1);
      chk({tag, " idle state"},     int'(fsm_state),  0);
   endtask

   // ---------------------------------------------------------------- vector table
   typedef struct {
      logic [1:0]    mode;
      logic [DW-1:0] data;
      int            n;
      int            idx[8];
   } vec_t;

   vec_t tbl[12];

   task automatic run_vec(input string tag, input vec_t v);
      wait_ready(tag);
      send(v.mode, v.data);
      for (int j = 0; j < v.n; j++) begin
         chk_idx($sformatf("%s #%0d", tag, j), v.idx[j], v.n - j, (j == v.n - 1) ? 1 : 0);
         if (j == 0) begin
            chk({tag, " ready in drain"}, int'(data_ready), 0);
            chk({tag, " state drain"},    int'(fsm_state),  1);
         end
         step();
      end
      chk_idle(tag);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test end");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------------------------------------------------------- test
   initial begin
      vec_t v;

      // The pointer column in the notes below is the round-robin pointer
      // after the row has drained.
      tbl[0]  = '{2'd0, 8'hA4, 3, '{2, 5, 7, 0, 0, 0, 0, 0}};  // ptr 0
      tbl[1]  = '{2'd1, 8'hA4, 3, '{7, 5, 2, 0, 0, 0, 0, 0}};  // ptr 0
      tbl[2]  = '{2'd2, 8'h05, 2, '{0, 2, 0, 0, 0, 0, 0, 0}};  // ptr 3
      tbl[3]  = '{2'd2, 8'h11, 2, '{4, 0, 0, 0, 0, 0, 0, 0}};  // ptr 1
      tbl[4]  = '{2'd3, 8'h81, 2, '{0, 7, 0, 0, 0, 0, 0, 0}};  // mode 11 = 00, ptr 1
      tbl[5]  = '{2'd2, 8'h03, 2, '{1, 0, 0, 0, 0, 0, 0, 0}};  // ptr 1
      tbl[6]  = '{2'd1, 8'h01, 1, '{0, 0, 0, 0, 0, 0, 0, 0}};  // ptr 1
      tbl[7]  = '{2'd0, 8'h80, 1, '{7, 0, 0, 0, 0, 0, 0, 0}};  // ptr 1
      tbl[8]  = '{2'd2, 8'h80, 1, '{7, 0, 0, 0, 0, 0, 0, 0}};  // ptr 0 (wrap)
      tbl[9]  = '{2'd2, 8'h42, 2, '{1, 6, 0, 0, 0, 0, 0, 0}};  // ptr 7
      tbl[10] = '{2'd2, 8'h81, 2, '{7, 0, 0, 0, 0, 0, 0, 0}};  // ptr 1
      tbl[11] = '{2'd1, 8'hFF, 8, '{7, 6, 5, 4, 3, 2, 1, 0}};  // ptr 1

      // ---- reset state
      step();
      step();
      chk("reset ready",     int'(data_ready), 0);
      chk("reset valid",     int'(enc_valid),  0);
      chk("reset value",     int'(enc_value),  0);
      chk("reset remaining", int'(remaining),  0);
      chk("reset last",      int'(last),       0);
      chk("reset no_match",  int'(no_match),   0);
      rst_n = 1'b1;
      step();
      chk("post-reset ready", int'(data_ready), 1);

      // ---- table-driven drains, continuous downstream ready
      for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

      // ---- back-pressure: index 2 held for three cycles, then 5 and 7
      wait_ready("stall");
      enc_ready = 1'b0;
      send(2'd0, 8'hA4);
      for (int k = 0; k < 3; k++) begin
         chk_idx($sformatf("stall hold%0d", k), 2, 3, 0);
         if (k == 2) enc_ready = 1'b1;
         step();
      end
      chk_idx("stall #1", 5, 2, 0);
      step();
      chk_idx("stall #2", 7, 1, 1);
      step();
      chk_idle("stall");

      // ---- all-zero vector
      wait_ready("zero");
      send(2'd0, 8'h00);
      chk("zero no_match", int'(no_match),   1);
      chk("zero valid",    int'(enc_valid),  0);
      chk("zero ready",    int'(data_ready), 1);
      step();
      chk("zero no_match drop", int'(no_match),  0);
      chk("zero valid after",   int'(enc_valid), 0);

      // ---- enable low mid-drain freezes the grant
      wait_ready("enable");
      send(2'd0, 8'hA4);
      chk_idx("enable first", 2, 3, 0);
      enable = 1'b0;
      step();
      chk("enable off valid", int'(enc_valid),  0);
      chk("enable off ready", int'(data_ready), 0);
      chk("enable off value", int'(enc_value),  2);
      chk("enable off rem",   int'(remaining),  3);
      step();
      chk("enable off value2", int'(enc_value), 2);
      enable = 1'b1;
      step();
      chk_idx("enable back", 2, 3, 0);
      step();
      chk_idx("enable #1", 5, 2, 0);
      step();
      chk_idx("enable #2", 7, 1, 1);
      step();
      chk_idle("enable");

      // ---- flush beats a simultaneous round-robin handshake (pointer 1 -> 2)
      wait_ready("rrflush");
      send(2'd2, 8'hFF);
      chk_idx("rrflush #0", 1, 8, 0);
      step();
      chk_idx("rrflush #1", 2, 7, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk_idle("rrflush");
      // Pointer must still be 2; a lost flush priority would leave it at 3.
      v = '{2'd2, 8'h0C, 2, '{2, 3, 0, 0, 0, 0, 0, 0}};
      run_vec("rrptr", v);

      // ---- flush after index 1 in low-priority mode
      wait_ready("flush");
      send(2'd0, 8'hFF);
      chk_idx("flush #0", 0, 8, 0);
      step();
      chk_idx("flush #1", 1, 7, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk_idle("flush");

      // ---- asynchronous reset mid-drain
      wait_ready("rstmid");
      send(2'd0, 8'hFF);
      chk_idx("rstmid #0", 0, 8, 0);
      step();
      chk_idx("rstmid #1", 1, 7, 0);
      rst_n = 1'b0;
      #1;
      chk("rstmid valid",     int'(enc_valid),  0);
      chk("rstmid value",     int'(enc_value),  0);
      chk("rstmid remaining", int'(remaining),  0);
      chk("rstmid last",      int'(last),       0);
      chk("rstmid ready",     int'(data_ready), 0);
      chk("rstmid no_match",  int'(no_match),   0);
      chk("rstmid state",     int'(fsm_state),  0);
      step();
      rst_n = 1'b1;
      step();
      chk("rstmid release ready", int'(data_ready), 1);
      // Pointer back at 0: 8'h11 must give 0 then 4 (a stale pointer of 4
      // would give 4 then 0).
      v = '{2'd2, 8'h11, 2, '{0, 4, 0, 0, 0, 0, 0, 0}};
      run_vec("rrreset", v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
